// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between the UART receiver and the
// Wishbone control block.
//  - A three-state capture FSM takes each byte the receiver flags, acks it
//    with a one-cycle pulse, and queues {frame_err, data}.
//  - The head entry is shown first-word-fall-through; i_pop discards it.
//  - o_irq is a registered level interrupt raised at the fill threshold.
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to add an idle-timeout
// interrupt source. The default build (macro undefined) is threshold-only.
module uart_rx_fifo #(
  parameter int DEPTH     = 16,
  parameter int THRESHOLD = 8,
  parameter int TIMEOUT   = 16000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   i_rx_data,
  input  logic                         i_rx_valid,
  input  logic                         i_frame_err,
  output logic                         o_rx_ack,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic                         i_clr_ovf,
  output logic [7:0]                   o_rd_data,
  output logic                         o_rd_ferr,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_ovf,
  output logic                         o_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic [AW:0] THR     = (AW + 1)'(THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        wr_req;
  logic        wr_en;
  logic        pop_en;
  logic        ovf_set;
  logic        full;
  logic        empty;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0] count_nxt;
  logic        tmo_flag_nxt;
  logic [8:0]  mem [DEPTH];

  // ---------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: WAIT holds until the receiver drops its valid level so
  // a byte held across several cycles is captured exactly once.
  // NOTE: a default assignment first in every always_comb prevents latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (i_rx_valid) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_WAIT;
      S_WAIT:  if (!i_rx_valid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: capture request in IDLE, ack pulse while in ACK.
  always_comb begin
    wr_req   = 1'b0;
    o_rx_ack = 1'b0;
    unique case (state)
      S_IDLE:  wr_req   = i_rx_valid;
      S_ACK:   o_rx_ack = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Pointers and status
  // ---------------------------------------------------------------------

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees a slot, so a write to a full buffer is
  // still accepted then. Flush takes precedence over both.
  assign pop_en  = i_pop && !empty && !i_flush;
  assign wr_en   = wr_req && (!full || pop_en) && !i_flush;
  assign ovf_set = wr_req && full && !pop_en;

  // Next pointer values; flush returns both pointers to zero.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (i_flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (wr_en)  wr_ptr_nxt = wr_ptr + PTR_ONE;
      if (pop_en) rd_ptr_nxt = rd_ptr + PTR_ONE;
    end
  end

  assign count_nxt = wr_ptr_nxt - rd_ptr_nxt;

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  // Entry storage, written on accepted captures.
  // NOTE: the array has no reset; its contents only matter behind a valid
  // pointer, and a reset would turn it into flops instead of RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {i_frame_err, i_rx_data};
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         o_ovf <= 1'b0;
    else if (ovf_set)   o_ovf <= 1'b1;
    else if (i_clr_ovf) o_ovf <= 1'b0;
  end

  // ---------------------------------------------------------------------
  // Idle timeout (optional)
  // ---------------------------------------------------------------------
`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_flag;
  logic          activity;

  assign activity = i_flush || wr_en || pop_en;

  // Flag rises after TIMEOUT quiet cycles with data waiting; any write,
  // pop or flush clears it.
  always_comb begin
    tmo_flag_nxt = tmo_flag;
    if (activity)                          tmo_flag_nxt = 1'b0;
    else if (!empty && tmo_cnt == TMO_LAST) tmo_flag_nxt = 1'b1;
  end

  // Idle counter and flag register; the counter parks at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      tmo_flag <= tmo_flag_nxt;
      if (activity || empty)     tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + TMO_ONE;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign tmo_flag_nxt   = 1'b0;
`endif

  // Interrupt register, computed from the next count so it moves together
  // with o_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_irq <= 1'b0;
    else        o_irq <= (count_nxt >= THR) || tmo_flag_nxt;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // Head is forced to zero while empty so unwritten storage never shows.
  assign {o_rd_ferr, o_rd_data} = empty ? 9'h000 : mem[rd_ptr[AW-1:0]];
  assign o_empty = empty;
  assign o_full  = full;
  assign o_count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH=16, THRESHOLD=8).
// Stimulus pushes every byte expected to be stored into a scoreboard queue;
// a monitor compares the head against the queue whenever a pop is issued.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_frame_err;
  logic       o_rx_ack;
  logic       i_pop;
  logic       i_flush;
  logic       i_clr_ovf;
  logic [7:0] o_rd_data;
  logic       o_rd_ferr;
  logic       o_empty;
  logic       o_full;
  logic [4:0] o_count;
  logic       o_ovf;
  logic       o_irq;

  int n_checks  = 0;
  int n_pass    = 0;
  int ack_total = 0;
  logic [8:0] exp_q[$];

  uart_rx_fifo #(.DEPTH(16), .THRESHOLD(8), .TIMEOUT(16000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .i_frame_err (i_frame_err),
    .o_rx_ack    (o_rx_ack),
    .i_pop       (i_pop),
    .i_flush     (i_flush),
    .i_clr_ovf   (i_clr_ovf),
    .o_rd_data   (o_rd_data),
    .o_rd_ferr   (o_rd_ferr),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_count     (o_count),
    .o_ovf       (o_ovf),
    .o_irq       (o_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: counts ack pulses and checks the head on every issued pop.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_rx_ack) ack_total++;
      if (i_pop) begin
        check("pop_nonempty", {31'd0, !o_empty}, {31'd0, exp_q.size() != 0});
        if (!o_empty && exp_q.size() != 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("pop_head", {23'd0, o_rd_ferr, o_rd_data}, {23'd0, e});
        end
      end
    end
  end

  // Present one byte, wait (bounded) for the ack, then release valid.
  task automatic send(input logic [7:0] d, input logic fe, input logic stored);
    bit got = 0;
    @(posedge clk); #1;
    i_rx_data = d; i_frame_err = fe; i_rx_valid = 1'b1;
    if (stored) exp_q.push_back({fe, d});
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (o_rx_ack) got = 1;
    end
    check("ack_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic pop1();
    @(posedge clk); #1; i_pop = 1'b1;
    @(posedge clk); #1; i_pop = 1'b0;
  endtask

  initial begin
    int a0;
    bit seen;
    rst_n = 1'b0; i_rx_data = 8'h00; i_rx_valid = 1'b0; i_frame_err = 1'b0;
    i_pop = 1'b0; i_flush = 1'b0; i_clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_ack",   {31'd0, o_rx_ack}, 32'd0);
    check("rst_empty", {31'd0, o_empty},  32'd1);
    check("rst_full",  {31'd0, o_full},   32'd0);
    check("rst_count", {27'd0, o_count},  32'd0);
    check("rst_ovf",   {31'd0, o_ovf},    32'd0);
    check("rst_irq",   {31'd0, o_irq},    32'd0);
    check("rst_data",  {24'd0, o_rd_data}, 32'd0);
    check("rst_ferr",  {31'd0, o_rd_ferr}, 32'd0);

    // 1: 0xA5 held for 20 cycles is captured and acked once.
    @(posedge clk); #1;
    a0 = ack_total;
    i_rx_data = 8'hA5; i_frame_err = 1'b0; i_rx_valid = 1'b1;
    exp_q.push_back(9'h0A5);
    repeat (20) @(posedge clk);
    #1 i_rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t1_ack_once", ack_total - a0, 32'd1);
    check("t1_count",    {27'd0, o_count}, 32'd1);
    check("t1_data",     {24'd0, o_rd_data}, 32'hA5);
    pop1();
    check("t1_empty", {31'd0, o_empty}, 32'd1);

    // Pop while empty is ignored.
    pop1();
    check("empty_pop_count", {27'd0, o_count}, 32'd0);

    // 2: 16 bytes in order, full at 16, drain in order.
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b1);
    check("t2_full",  {31'd0, o_full},  32'd1);
    check("t2_count", {27'd0, o_count}, 32'd16);
    check("t2_irq",   {31'd0, o_irq},   32'd1);
    for (int i = 0; i < 16; i++) pop1();
    check("t2_empty", {31'd0, o_empty}, 32'd1);
    check("t2_irq0",  {31'd0, o_irq},   32'd0);

    // 3: full then 0xEE is acked but dropped; clear overflow.
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b0, 1'b1);
    send(8'hEE, 1'b0, 1'b0);
    check("t3_ovf",   {31'd0, o_ovf},     32'd1);
    check("t3_count", {27'd0, o_count},   32'd16);
    check("t3_head",  {24'd0, o_rd_data}, 32'h10);
    @(posedge clk); #1 i_clr_ovf = 1'b1;
    @(posedge clk); #1 i_clr_ovf = 1'b0;
    check("t3_ovf_clr", {31'd0, o_ovf}, 32'd0);

    // 4: full, pop and capture on the same edge.
    @(posedge clk); #1;
    a0 = ack_total;
    i_rx_data = 8'h55; i_frame_err = 1'b0; i_rx_valid = 1'b1; i_pop = 1'b1;
    exp_q.push_back(9'h055);
    @(posedge clk); #1 i_pop = 1'b0;
    check("t4_count", {27'd0, o_count}, 32'd16);
    check("t4_ovf",   {31'd0, o_ovf},   32'd0);
    @(posedge clk); #1 i_rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("t4_ack", ack_total - a0, 32'd1);
    for (int i = 0; i < 16; i++) pop1();
    check("t4_empty", {31'd0, o_empty}, 32'd1);

    // 5: frame-error tag at head, threshold interrupt.
    send(8'h3C, 1'b1, 1'b1);
    check("t5_ferr", {31'd0, o_rd_ferr}, 32'd1);
    for (int i = 1; i <= 6; i++) send(8'h40 + 8'(i), 1'b0, 1'b1);
    check("t5_count7", {27'd0, o_count}, 32'd7);
    check("t5_irq7",   {31'd0, o_irq},   32'd0);
    send(8'h47, 1'b0, 1'b1);
    check("t5_irq8", {31'd0, o_irq}, 32'd1);
    pop1();
    check("t5_irq_pop",   {31'd0, o_irq},   32'd0);
    check("t5_count_pop", {27'd0, o_count}, 32'd7);

    // Flush empties the buffer.
    @(posedge clk); #1 i_flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 i_flush = 1'b0;
    check("flush_count", {27'd0, o_count}, 32'd0);
    check("flush_empty", {31'd0, o_empty}, 32'd1);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    // 6a: one byte left idle raises the timeout interrupt.
    send(8'h77, 1'b0, 1'b1);
    repeat (15900) @(posedge clk);
    #1 check("t6_irq_early", {31'd0, o_irq}, 32'd0);
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (o_irq) seen = 1;
    end
    check("t6_tmo_irq", {31'd0, seen}, 32'd1);
    pop1();
    check("t6_irq_pop", {31'd0, o_irq}, 32'd0);
`endif

    // 6b: reset asserted mid-byte returns every output to reset values.
    @(posedge clk); #1;
    i_rx_data = 8'h99; i_frame_err = 1'b1; i_rx_valid = 1'b1;
    @(posedge clk); #1;
    check("t6_mid_ack", {31'd0, o_rx_ack}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ack",   {31'd0, o_rx_ack}, 32'd0);
    check("t6_rst_empty", {31'd0, o_empty},  32'd1);
    check("t6_rst_count", {27'd0, o_count},  32'd0);
    check("t6_rst_ovf",   {31'd0, o_ovf},    32'd0);
    check("t6_rst_irq",   {31'd0, o_irq},    32'd0);
    check("t6_rst_data",  {24'd0, o_rd_data}, 32'd0);
    check("t6_rst_ferr",  {31'd0, o_rd_ferr}, 32'd0);
    i_rx_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
